// File: rtl/vga_scan_ctrl.sv
// Scan sequencer for the parallax VGA pipeline: raster counters, two-stage sync/RGB alignment,
// and double-buffered per-layer scroll registers. Define VGA_SCAN_AUTOSCROLL_EN to implement autoscroll.
module vga_scan_ctrl #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 24,
   parameter int H_SYNC     = 40,
   parameter int H_BACK     = 128,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 9,
   parameter int V_SYNC     = 3,
   parameter int V_BACK     = 28,
   parameter int NUM_LAYERS = 3
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    pix_en_i,
   input  logic                    cfg_we_i,
   input  logic [1:0]              cfg_addr_i,
   input  logic [9:0]              cfg_wdata_i,
   input  logic [2:0]              rgb_i,
   output logic [9:0]              x_o,
   output logic [9:0]              y_o,
   output logic                    visible_o,
   output logic                    line_start_o,
   output logic                    frame_start_o,
   output logic [10*NUM_LAYERS-1:0] scroll_o,
   output logic [7:0]              frame_cnt_o,
   output logic                    hsync_o,
   output logic                    vsync_o,
   output logic [2:0]              rgb_o
);

   localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);

   logic [9:0] h_q, h_d, v_q, v_d;
   logic [7:0] frame_q, frame_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic       vis_q, vis_d, line_q, line_d, fstart_q, fstart_d;
   logic       hs1_q, hs1_d, vs1_q, vs1_d;
   logic       hsync_q, hsync_d, vsync_q, vsync_d;
   logic [2:0] rgb_q, rgb_d;
   logic       enable_q, enable_d;
   logic [NUM_LAYERS-1:0][9:0] shadow_q, shadow_d, active_q, active_d;
   logic       h_wrap, v_wrap, commit;
`ifdef VGA_SCAN_AUTOSCROLL_EN
   localparam logic [10:0] SCROLL_MOD = 11'(H_VISIBLE);
   logic                  autoscroll_q, autoscroll_d;
   logic [NUM_LAYERS-1:0] dirty_q, dirty_d;
   logic [10:0]           step_sum;
`endif

   assign h_wrap = (h_q == H_LAST);
   assign v_wrap = (v_q == V_LAST);
   // Commit fires on the tick that moves the raster into the first vblank line.
   assign commit = enable_q && pix_en_i && h_wrap && (v_q == V_VIS_LAST);

   always_comb begin
      h_d      = h_q;
      v_d      = v_q;
      frame_d  = frame_q;
      x_d      = x_q;
      y_d      = y_q;
      vis_d    = vis_q;
      line_d   = line_q;
      fstart_d = fstart_q;
      hs1_d    = hs1_q;
      vs1_d    = vs1_q;
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
      rgb_d    = rgb_q;
      if (!enable_q) begin
         h_d      = '0;
         v_d      = '0;
         frame_d  = '0;
         x_d      = '0;
         y_d      = '0;
         vis_d    = 1'b0;
         line_d   = 1'b0;
         fstart_d = 1'b0;
         hs1_d    = 1'b1;
         vs1_d    = 1'b1;
         hsync_d  = 1'b1;
         vsync_d  = 1'b1;
         rgb_d    = '0;
      end else if (pix_en_i) begin
         h_d = h_wrap ? '0 : h_q + 10'd1;
         if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + 10'd1;
            if (v_wrap) frame_d = frame_q + 8'd1;
         end
         x_d      = h_q;
         y_d      = v_q;
         vis_d    = (h_q < H_VIS) && (v_q < V_VIS);
         line_d   = (h_q == '0);
         fstart_d = (h_q == '0) && (v_q == '0);
         hs1_d    = !((h_q >= HS_START) && (h_q < HS_END));
         vs1_d    = !((v_q >= VS_START) && (v_q < VS_END));
         rgb_d    = vis_q ? rgb_i : 3'b000;
         hsync_d  = hs1_q;
         vsync_d  = vs1_q;
      end
   end

   // Commit reads the pre-write shadow, so a write colliding with commit lands one frame later.
   always_comb begin
      enable_d = enable_q;
      shadow_d = shadow_q;
      active_d = active_q;
`ifdef VGA_SCAN_AUTOSCROLL_EN
      autoscroll_d = autoscroll_q;
      dirty_d      = dirty_q;
      step_sum     = '0;
`endif
      if (commit) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
`ifdef VGA_SCAN_AUTOSCROLL_EN
            if (autoscroll_q && !dirty_q[i]) begin
               step_sum = {1'b0, active_q[i]} + 11'(i + 1);
               if (step_sum >= SCROLL_MOD) step_sum = step_sum - SCROLL_MOD;
               active_d[i] = step_sum[9:0];
            end else begin
               active_d[i] = shadow_q[i];
            end
            dirty_d[i] = 1'b0;
`else
            active_d[i] = shadow_q[i];
`endif
         end
      end
      if (cfg_we_i) begin
         if (cfg_addr_i == 2'd3) begin
            enable_d = cfg_wdata_i[0];
`ifdef VGA_SCAN_AUTOSCROLL_EN
            autoscroll_d = cfg_wdata_i[1];
`endif
         end
         for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cfg_addr_i == 2'(i)) begin
               shadow_d[i] = cfg_wdata_i;
`ifdef VGA_SCAN_AUTOSCROLL_EN
               dirty_d[i] = 1'b1;
`endif
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         h_q      <= '0;
         v_q      <= '0;
         frame_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         vis_q    <= 1'b0;
         line_q   <= 1'b0;
         fstart_q <= 1'b0;
         hs1_q    <= 1'b1;
         vs1_q    <= 1'b1;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         rgb_q    <= '0;
         enable_q <= 1'b1;
         shadow_q <= '0;
         active_q <= '0;
`ifdef VGA_SCAN_AUTOSCROLL_EN
         autoscroll_q <= 1'b0;
         dirty_q      <= '0;
`endif
      end else begin
         h_q      <= h_d;
         v_q      <= v_d;
         frame_q  <= frame_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vis_q    <= vis_d;
         line_q   <= line_d;
         fstart_q <= fstart_d;
         hs1_q    <= hs1_d;
         vs1_q    <= vs1_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         rgb_q    <= rgb_d;
         enable_q <= enable_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
`ifdef VGA_SCAN_AUTOSCROLL_EN
         autoscroll_q <= autoscroll_d;
         dirty_q      <= dirty_d;
`endif
      end
   end

   assign x_o           = x_q;
   assign y_o           = y_q;
   assign visible_o     = vis_q;
   assign line_start_o  = line_q;
   assign frame_start_o = fstart_q;
   assign scroll_o      = active_q;
   assign frame_cnt_o   = frame_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign rgb_o         = rgb_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: a full-size instance for 640x480 line timing and a
// shrunken-raster instance (25x10 ticks per frame) for frame, scroll and enable behaviour.
module tb_vga_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       pix_en;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [9:0] cfg_wdata;
   logic [2:0] rgb_in;

   logic [9:0]  x, y;
   logic        vis, ls, fs, hs, vs;
   logic [29:0] scroll;
   logic [7:0]  fcnt;
   logic [2:0]  rgb_out;

   logic [9:0]  f_x, f_y;
   logic        f_vis, f_ls, f_fs, f_hs, f_vs;
   logic [29:0] f_scroll;
   logic [7:0]  f_fcnt;
   logic [2:0]  f_rgb;

   int checks = 0;
   int errors = 0;
   int n = 0;

   always #5 clk = ~clk;

   // Small raster: h 0..24 (visible <16, hsync low 18..20), v 0..9 (visible <6, vsync low 7..8).
   vga_scan_ctrl #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .NUM_LAYERS(3)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .pix_en_i(pix_en), .cfg_we_i(cfg_we),
      .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .rgb_i(rgb_in),
      .x_o(x), .y_o(y), .visible_o(vis), .line_start_o(ls), .frame_start_o(fs),
      .scroll_o(scroll), .frame_cnt_o(fcnt), .hsync_o(hs), .vsync_o(vs), .rgb_o(rgb_out)
   );

   vga_scan_ctrl dut_full (
      .wb_clk_i(clk), .wb_rst_i(rst), .pix_en_i(pix_en), .cfg_we_i(cfg_we),
      .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .rgb_i(rgb_in),
      .x_o(f_x), .y_o(f_y), .visible_o(f_vis), .line_start_o(f_ls), .frame_start_o(f_fs),
      .scroll_o(f_scroll), .frame_cnt_o(f_fcnt), .hsync_o(f_hs), .vsync_o(f_vs), .rgb_o(f_rgb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic run_to(input int target);
      while (n < target) tick();
   endtask

   task automatic apply_reset();
      rst = 1'b1; pix_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; rgb_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0;
   endtask

   task automatic cfg_write(input logic [1:0] addr, input logic [9:0] data);
      cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if ({x, y} !== 20'd0) begin errors++; $display("[TB] FAIL reset_xy: got x=%0d y=%0d want 0 0", x, y); end
      checks++; if ({vis, ls, fs} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000", {vis, ls, fs}); end
      checks++; if ({hs, vs} !== 2'b11) begin errors++; $display("[TB] FAIL reset_sync: got %b want 11", {hs, vs}); end
      checks++; if (rgb_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_rgb: got %0d want 0", rgb_out); end
      checks++; if (scroll !== 30'd0 || fcnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_scroll_fcnt: got %h %0d want 0 0", scroll, fcnt); end
      pix_en = 1'b1;
      tick();
      checks++; if ({x, y} !== 20'd0 || {vis, ls, fs} !== 3'b111) begin errors++; $display("[TB] FAIL first_tick: got x=%0d y=%0d flags=%b want 0 0 111", x, y, {vis, ls, fs}); end
      tick();
      checks++; if (x !== 10'd1 || {ls, fs} !== 2'b00) begin errors++; $display("[TB] FAIL second_tick: got x=%0d ls/fs=%b want 1 00", x, {ls, fs}); end
      run_to(30);
      rst = 1'b1;
      #2;
      checks++; if ({x, y} !== 20'd0 || hs !== 1'b1) begin errors++; $display("[TB] FAIL async_reset: got x=%0d y=%0d hs=%b want 0 0 1", x, y, hs); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0;
      tick();
      checks++; if ({x, y} !== 20'd0 || fs !== 1'b1) begin errors++; $display("[TB] FAIL restart_after_reset: got x=%0d y=%0d fs=%b want 0 0 1", x, y, fs); end
   endtask

   task automatic test_hsync_full();
      int first_low = -1;
      int lows = 0;
      int run_len = 0;
      int max_run = 0;
      int vs_lows = 0;
      apply_reset();
      pix_en = 1'b1;
      for (int k = 1; k <= 1700; k++) begin
         tick();
         if (!f_hs) begin
            lows++;
            run_len++;
            if (first_low < 0) first_low = n;
            if (run_len > max_run) max_run = run_len;
         end else begin
            run_len = 0;
         end
         if (!f_vs) vs_lows++;
      end
      checks++; if (first_low !== 666) begin errors++; $display("[TB] FAIL full_hsync_first: got tick %0d want 666", first_low); end
      checks++; if (lows !== 80) begin errors++; $display("[TB] FAIL full_hsync_low_total: got %0d want 80", lows); end
      checks++; if (max_run !== 40) begin errors++; $display("[TB] FAIL full_hsync_width: got %0d want 40", max_run); end
      checks++; if (vs_lows !== 0) begin errors++; $display("[TB] FAIL full_vsync_quiet: got %0d want 0", vs_lows); end
   endtask

   task automatic test_frame();
      int rgb_on = 0, overlap = 0, hs_low = 0, vs_low = 0, ls_cnt = 0, fs_cnt = 0;
      apply_reset();
      pix_en = 1'b1;
      rgb_in = 3'b111;
      for (int k = 1; k <= 252; k++) begin
         tick();
         if (n == 3) begin
            checks++; if (rgb_out !== 3'b111) begin errors++; $display("[TB] FAIL rgb_pass: got %b want 111", rgb_out); end
         end
         if (n == 18) begin
            checks++; if (rgb_out !== 3'b000) begin errors++; $display("[TB] FAIL rgb_blank: got %b want 000", rgb_out); end
         end
         if (n >= 3) begin
            if (rgb_out != 3'd0) rgb_on++;
            if (rgb_out != 3'd0 && (!hs || !vs)) overlap++;
            if (!hs) hs_low++;
            if (!vs) vs_low++;
            if (ls) ls_cnt++;
            if (fs) fs_cnt++;
         end
      end
      checks++; if (rgb_on !== 96) begin errors++; $display("[TB] FAIL frame_rgb_count: got %0d want 96", rgb_on); end
      checks++; if (overlap !== 0) begin errors++; $display("[TB] FAIL rgb_during_sync: got %0d want 0", overlap); end
      checks++; if (hs_low !== 30) begin errors++; $display("[TB] FAIL frame_hsync_low: got %0d want 30", hs_low); end
      checks++; if (vs_low !== 50) begin errors++; $display("[TB] FAIL frame_vsync_low: got %0d want 50", vs_low); end
      checks++; if (ls_cnt !== 10 || fs_cnt !== 1) begin errors++; $display("[TB] FAIL start_pulses: got ls=%0d fs=%0d want 10 1", ls_cnt, fs_cnt); end
      checks++; if (fcnt !== 8'd1) begin errors++; $display("[TB] FAIL frame_cnt: got %0d want 1", fcnt); end
      rgb_in = 3'b000;
   endtask

   task automatic test_scroll();
      apply_reset();
      pix_en = 1'b1;
      run_to(60);
      cfg_write(2'd1, 10'd100);
      checks++; if (scroll[19:10] !== 10'd0) begin errors++; $display("[TB] FAIL scroll_after_write: got %0d want 0", scroll[19:10]); end
      run_to(149);
      checks++; if (scroll[19:10] !== 10'd0) begin errors++; $display("[TB] FAIL scroll_before_commit: got %0d want 0", scroll[19:10]); end
      tick();
      checks++; if (scroll !== {10'd0, 10'd100, 10'd0}) begin errors++; $display("[TB] FAIL scroll_commit: got %h want %h", scroll, {10'd0, 10'd100, 10'd0}); end
   endtask

   task automatic test_back_to_back();
      run_to(199);
      cfg_write(2'd0, 10'd55);
      run_to(399);
      cfg_write(2'd0, 10'd77);
      checks++; if (scroll[9:0] !== 10'd55) begin errors++; $display("[TB] FAIL collide_old: got %0d want 55", scroll[9:0]); end
      run_to(649);
      checks++; if (scroll[9:0] !== 10'd55) begin errors++; $display("[TB] FAIL collide_hold: got %0d want 55", scroll[9:0]); end
      tick();
      checks++; if (scroll[9:0] !== 10'd77) begin errors++; $display("[TB] FAIL collide_next: got %0d want 77", scroll[9:0]); end
   endtask

   task automatic test_enable();
      rgb_in = 3'b111;
      run_to(760);
      cfg_write(2'd3, 10'd0);
      tick();
      checks++; if ({x, y} !== 20'd0 || {vis, hs, vs} !== 3'b011 || rgb_out !== 3'd0) begin errors++; $display("[TB] FAIL disable_clear: got x=%0d y=%0d vis/hs/vs=%b rgb=%0d want 0 0 011 0", x, y, {vis, hs, vs}, rgb_out); end
      repeat (5) tick();
      checks++; if ({x, y} !== 20'd0) begin errors++; $display("[TB] FAIL disable_hold: got x=%0d y=%0d want 0 0", x, y); end
      cfg_write(2'd2, 10'd9);
      cfg_write(2'd3, 10'd1);
      n = 0;
      tick();
      checks++; if ({x, y} !== 20'd0 || fs !== 1'b1) begin errors++; $display("[TB] FAIL reenable_start: got x=%0d y=%0d fs=%b want 0 0 1", x, y, fs); end
      run_to(149);
      checks++; if (scroll[29:20] !== 10'd0) begin errors++; $display("[TB] FAIL disabled_write_pending: got %0d want 0", scroll[29:20]); end
      tick();
      checks++; if (scroll !== {10'd9, 10'd100, 10'd77}) begin errors++; $display("[TB] FAIL disabled_write_commit: got %h want %h", scroll, {10'd9, 10'd100, 10'd77}); end
      rgb_in = 3'b000;
   endtask

   task automatic test_autoscroll();
      apply_reset();
      pix_en = 1'b1;
`ifdef VGA_SCAN_AUTOSCROLL_EN
      cfg_write(2'd3, 10'd3);
      run_to(1150);
      checks++; if (scroll !== {10'd15, 10'd10, 10'd5}) begin errors++; $display("[TB] FAIL autoscroll_5: got %h want %h", scroll, {10'd15, 10'd10, 10'd5}); end
      run_to(1400);
      checks++; if (scroll !== {10'd2, 10'd12, 10'd6}) begin errors++; $display("[TB] FAIL autoscroll_wrap: got %h want %h", scroll, {10'd2, 10'd12, 10'd6}); end
      run_to(1500);
      cfg_write(2'd0, 10'd1);
      run_to(1650);
      checks++; if (scroll !== {10'd5, 10'd14, 10'd1}) begin errors++; $display("[TB] FAIL autoscroll_override: got %h want %h", scroll, {10'd5, 10'd14, 10'd1}); end
`else
      cfg_write(2'd1, 10'd40);
      cfg_write(2'd3, 10'd3);
      run_to(150);
      checks++; if (scroll !== {10'd0, 10'd40, 10'd0}) begin errors++; $display("[TB] FAIL bit1_ignored_1: got %h want %h", scroll, {10'd0, 10'd40, 10'd0}); end
      run_to(400);
      checks++; if (scroll !== {10'd0, 10'd40, 10'd0}) begin errors++; $display("[TB] FAIL bit1_ignored_2: got %h want %h", scroll, {10'd0, 10'd40, 10'd0}); end
`endif
   endtask

   task automatic test_pix_scaled();
      int lows = 0, first_low = -1, edges = 0, glitches = 0;
      logic prev_hs;
      logic [9:0] prev_x;
      apply_reset();
      prev_hs = hs;
      prev_x = x;
      for (int c = 1; c <= 200; c++) begin
         pix_en = ((c % 4) == 1);
         @(posedge clk);
         #1;
         if (!hs) begin
            lows++;
            if (first_low < 0) first_low = c;
         end
         if (hs !== prev_hs) edges++;
         if (!pix_en && x !== prev_x) glitches++;
         prev_hs = hs;
         prev_x = x;
      end
      checks++; if (first_low !== 77) begin errors++; $display("[TB] FAIL scaled_first_low: got %0d want 77", first_low); end
      checks++; if (lows !== 24) begin errors++; $display("[TB] FAIL scaled_low_total: got %0d want 24", lows); end
      checks++; if (edges !== 4 || glitches !== 0) begin errors++; $display("[TB] FAIL scaled_glitch: got edges=%0d glitches=%0d want 4 0", edges, glitches); end
   endtask

   initial begin
      test_hsync_full();
      test_reset();
      test_frame();
      test_scroll();
      test_back_to_back();
      test_enable();
      test_autoscroll();
      test_pix_scaled();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
